// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - loadable four-digit BCD countdown timer with seven-segment drive; BCD_TIMER_BLANK_EN enables leading-zero blanking
module bcd_down_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] count,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic [19:0] tick;
    logic [19:0] tick_next;
    logic [15:0] count_next;
    logic [15:0] count_dec;
    logic        done_next;
    logic        blank3;
    logic        blank2;
    logic        blank1;

    // Digits above 9 are clamped so the counter only ever holds legal BCD.
    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // BCD decrement: a zero digit wraps to 9 and borrows from the next digit.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low gfedcba pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign count_dec = bcd_dec(count);

    // State, count, tick counter and done pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            tick  <= 20'd0;
            count <= 16'h0000;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            tick  <= tick_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    // Next state: load wins over pause, pause wins over start; a resume edge counts as a run cycle.
    always_comb begin
        state_next = state;
        tick_next  = tick;
        count_next = count;
        done_next  = 1'b0;
        if (load) begin
            state_next = IDLE;
            tick_next  = 20'd0;
            count_next = bcd_clamp(load_value);
        end else begin
            case (state)
                IDLE: begin
                    if (start && !pause) begin
                        if (count == 16'h0000) begin
                            state_next = EXPIRED;
                            done_next  = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN, PAUSED: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (state == RUN || start) begin
                        state_next = RUN;
                        if (tick == TICK_LAST) begin
                            tick_next  = 20'd0;
                            count_next = count_dec;
                            if (count_dec == 16'h0000) begin
                                state_next = EXPIRED;
                                done_next  = 1'b1;
                            end
                        end else begin
                            tick_next = tick + 20'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decode and display drive; the decimal point sits after the seconds digit.
    always_comb begin
        running = (state == RUN);
        expired = (state == EXPIRED);
        blank3  = 1'b0;
        blank2  = 1'b0;
        blank1  = 1'b0;
`ifdef BCD_TIMER_BLANK_EN
        blank3  = (count[15:12] == 4'd0);
        blank2  = blank3 && (count[11:8] == 4'd0);
        blank1  = blank2 && (count[7:4] == 4'd0);
`endif
        HEX3 = {1'b0, blank3 ? 7'h7F : seg7(count[15:12])};
        HEX2 = {1'b1, blank2 ? 7'h7F : seg7(count[11:8])};
        HEX1 = {1'b1, blank1 ? 7'h7F : seg7(count[7:4])};
        HEX0 = {1'b1, seg7(count[3:0])};
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - self-checking bench for bcd_down_timer with a decimal reference model
module tb_bcd_down_timer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_EXP    = 3;

    typedef struct {
        int val;
        int ticks;
        int mode;
        bit done;
    } mst_t;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;

    logic [15:0] d_count   [2];
    logic        d_running [2];
    logic        d_done    [2];
    logic        d_expired [2];
    logic [7:0]  d_hex     [2][4];

    mst_t ms [2];
    int   divs [2] = '{4, 1};
    int   pow10 [4] = '{1, 10, 100, 1000};
    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bcd_down_timer #(.TICK_DIV(4)) u_dut4 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .count(d_count[0]), .running(d_running[0]),
        .done(d_done[0]), .expired(d_expired[0]),
        .HEX0(d_hex[0][0]), .HEX1(d_hex[0][1]), .HEX2(d_hex[0][2]), .HEX3(d_hex[0][3])
    );

    bcd_down_timer #(.TICK_DIV(1)) u_dut1 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .count(d_count[1]), .running(d_running[1]),
        .done(d_done[1]), .expired(d_expired[1]),
        .HEX0(d_hex[1][0]), .HEX1(d_hex[1][1]), .HEX2(d_hex[1][2]), .HEX3(d_hex[1][3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int clamp_dec(input logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_hex(input int v, input int pos);
        logic [6:0] seg;
        seg = segtab[(v / pow10[pos]) % 10];
`ifdef BCD_TIMER_BLANK_EN
        if (pos > 0 && v < pow10[pos]) seg = 7'h7F;
`endif
        return {(pos == 3) ? 1'b0 : 1'b1, seg};
    endfunction

    // Reference: remaining time as a plain integer, stepping one clock edge at a time.
    function automatic mst_t mstep(input mst_t s, input int div, input bit rst, input bit ld,
                                   input logic [15:0] lv, input bit st, input bit ps);
        mst_t n;
        n      = s;
        n.done = 1'b0;
        if (rst) begin
            n.val = 0; n.ticks = 0; n.mode = M_IDLE;
        end else if (ld) begin
            n.val = clamp_dec(lv); n.ticks = 0; n.mode = M_IDLE;
        end else if (s.mode == M_IDLE) begin
            if (st && !ps) begin
                if (s.val == 0) begin
                    n.mode = M_EXP; n.done = 1'b1;
                end else begin
                    n.mode = M_RUN;
                end
            end
        end else if (s.mode == M_RUN && ps) begin
            n.mode = M_PAUSED;
        end else if (s.mode == M_RUN || (s.mode == M_PAUSED && st && !ps)) begin
            n.mode  = M_RUN;
            n.ticks = s.ticks + 1;
            if (n.ticks == div) begin
                n.ticks = 0;
                n.val   = s.val - 1;
                if (n.val == 0) begin
                    n.mode = M_EXP; n.done = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            ms[k] <= mstep(ms[k], divs[k], reset, load, load_value, start, pause);
    end

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual %h required %h", name, k, act, exp);
        end
    endtask

    // Every cycle, both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("count", k, d_count[k], to_bcd(ms[k].val));
                chk("running", k, 16'(d_running[k]), 16'(ms[k].mode == M_RUN));
                chk("done", k, 16'(d_done[k]), 16'(ms[k].done));
                chk("expired", k, 16'(d_expired[k]), 16'(ms[k].mode == M_EXP));
                for (int p = 0; p < 4; p++)
                    chk("hex", k, 16'(d_hex[k][p]), 16'(exp_hex(ms[k].val, p)));
            end
        end
    end

    task automatic cyc;
        @(negedge clock);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_value = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    logic [7:0] blank_hex3;

    initial begin
`ifdef BCD_TIMER_BLANK_EN
        blank_hex3 = 8'h7F;
`else
        blank_hex3 = 8'h40;
`endif
        reset = 1'b1; load = 1'b0; load_value = 16'h0000; start = 1'b0; pause = 1'b0;
        cyc();
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", 0, d_count[0], 16'h0000);
        chk("rst_flags", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0000);
        chk("rst_hex0", 0, 16'(d_hex[0][0]), 16'h00C0);
        chk("rst_hex3", 0, 16'(d_hex[0][3]), 16'(blank_hex3));

        // Plain countdown of 3 at TICK_DIV=4.
        do_load(16'h0003);
        do_start();
        chk("a_run", 0, 16'(d_running[0]), 16'h0001);
        repeat (3) cyc();
        chk("a_e3", 0, d_count[0], 16'h0003);
        cyc();
        chk("a_e4", 0, d_count[0], 16'h0002);
        repeat (4) cyc();
        chk("a_e8", 0, d_count[0], 16'h0001);
        repeat (4) cyc();
        chk("a_e12", 0, d_count[0], 16'h0000);
        chk("a_e12_flags", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0003);
        cyc();
        chk("a_e13_flags", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0001);

        // Borrow across all digits at TICK_DIV=1.
        do_load(16'h1000);
        do_start();
        cyc();
        chk("b_count", 1, d_count[1], 16'h0999);
        chk("b_hex3", 1, 16'(d_hex[1][3]), 16'(blank_hex3));
        chk("b_hex2", 1, 16'(d_hex[1][2]), 16'h0090);
        chk("b_hex1", 1, 16'(d_hex[1][1]), 16'h0090);
        chk("b_hex0", 1, 16'(d_hex[1][0]), 16'h0090);

        // Pause for ten cycles then resume: first decrement lands at E0+14.
        do_load(16'h0002);
        do_start();
        cyc();
        pause = 1'b1;
        cyc();
        chk("c_paused", 0, 16'(d_running[0]), 16'h0000);
        repeat (9) cyc();
        pause = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("c_e12", 0, {d_count[0][14:0], d_running[0]}, 16'h0005);
        cyc();
        chk("c_e13", 0, d_count[0], 16'h0002);
        cyc();
        chk("c_e14", 0, d_count[0], 16'h0001);

        // Clamp on load, then immediate expiry from zero.
        do_load(16'hA5F3);
        chk("d_clamp", 0, d_count[0], 16'h9593);
        do_load(16'h0000);
        do_start();
        chk("d_zero_flags", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0003);
        do_start();
        chk("d_exp_start", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0001);

        // Reload mid-run, then reset mid-run.
        do_load(16'h0022);
        do_start();
        repeat (4) cyc();
        chk("e_mid", 0, d_count[0], 16'h0021);
        do_load(16'h0050);
        chk("e_reload", 0, d_count[0], 16'h0050);
        chk("e_reload_flags", 0, {13'd0, d_running[0], d_done[0], d_expired[0]}, 16'h0000);
        do_start();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("e_rst_count", 0, d_count[0], 16'h0000);
        chk("e_rst_hex0", 0, 16'(d_hex[0][0]), 16'h00C0);
        chk("e_rst_hex3", 0, 16'(d_hex[0][3]), 16'(blank_hex3));

        // pause and start together in RUN pauses.
        do_load(16'h0005);
        do_start();
        pause = 1'b1; start = 1'b1;
        cyc();
        pause = 1'b0; start = 1'b0;
        chk("f_both", 0, {d_count[0][14:0], d_running[0]}, 16'h000A);

        // Random traffic checked against the model.
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(199) == 0);
            load       = ($urandom_range(39) == 0);
            load_value = $urandom_range(1) ? 16'($urandom) : {12'h000, 4'($urandom)};
            start      = ($urandom_range(5) == 0);
            pause      = ($urandom_range(9) == 0);
            cyc();
        end
        reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Loadable four-digit BCD countdown timer with a seven-segment display drive. It runs the countdown counterpart of the free-running BCD up-counter, decrementing a loaded value once per prescaled tick. It flags expiry for the reaction-timer control logic, which uses it for the random pre-stimulus delay and for timeout windows. Display outputs drive the same four on-board digits as the up-counter.

## Interface
- TICK_DIV, 50000: clock cycles per count step (1 ms at 50 MHz); legal range 1..2^20-1.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- load  in  1  loads load_value; single-cycle pulse or level.
- load_value  in  16  four BCD digits; [15:12] is the most significant digit.
- start  in  1  begin or resume the countdown.
- pause  in  1  suspend the countdown.
- count  out  16  current BCD value.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on expiry.
- expired  out  1  level; high from expiry until the next load or reset.
- HEX0..HEX3  out  8 each  active-low segments: [6:0] = gfedcba, [7] = decimal point. HEX0 is the least significant digit.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Reset forces IDLE, count=0, tick counter=0, running/done/expired=0.
- Input priority: reset > load > pause > start.
- Load (any state):
  - Goes to IDLE and clears the tick counter, expired and done.
  - count = load_value, with each digit >9 clamped to 9.
- IDLE:
  - start with count≠0 → RUN.
  - start with count=0 → EXPIRED, with done pulsed.
- RUN:
  - The tick counter increments every cycle.
  - At TICK_DIV-1 the tick counter returns to 0 and count decrements by 1 in BCD. Digits borrow 0→9 into the next digit, e.g. 1000→0999.
  - A decrement that produces 0000 → EXPIRED.
  - pause → PAUSED with the tick counter held.
  - start is ignored.
- PAUSED: start (without pause) → RUN; the tick counter resumes from its held value.
- EXPIRED: count holds at 0000; start and pause are ignored.
- count never underflows; 0000 is only reached via expiry.
- Segment encode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, gfedcba).
  - Decimal point lit on HEX3 only (HEX3[7]=0, others 1), giving an X.XXX seconds display.

## Timing
- All state, count, running, done and expired values are registered. HEX outputs are combinational from count and track it in the same cycle.
- If start is sampled at edge E0, running=1 after E0. The first decrement happens at edge E0+TICK_DIV.
- A loaded value N reaches 0000 at edge E0+N·TICK_DIV, excluding paused cycles. done=1 and expired=1 after that same edge. done drops after the next edge.
- start in IDLE with count=0: done and expired are high after the sampling edge.
- pause takes effect at its sampling edge. A decrement due on that same edge does not occur, and the tick counter holds TICK_DIV-1.
- Load during RUN cancels the run with no done pulse. Reset mid-run returns all outputs to reset values at the next edge.
- TICK_DIV=1: count decrements every cycle in RUN.

## Configuration
- BCD_TIMER_BLANK_EN defined: leading-zero blanking.
  - HEX3, then HEX2, then HEX1 show all segments off (7F) while that digit and all more significant digits are 0.
  - HEX0 is always shown. The decimal point is unaffected.
- Undefined: all four digits always display, including leading zeros.

## Test plan
- TICK_DIV=4, load 0003, start → count 0002/0001/0000 at E0+4/+8/+12; done high exactly one cycle after E0+12; expired stays 1; running 0.
- TICK_DIV=1, load 1000, start → count 0999 after one edge; HEX3=40, HEX2=10, HEX1=10, HEX0=10, HEX3[7]=0.
- TICK_DIV=4, load 0002, start, pause at E0+2 for 10 cycles, then start → first decrement at E0+14 (4 running cycles total).
- Load A5F3 → count 9593; start with count 0000 → expired=1 and a one-cycle done pulse after the sampling edge.
- Load 0050 mid-run (count 0021) → IDLE, count 0050, done never asserted. Reset mid-run → count 0000, running/done/expired 0; HEX0=40, with HEX3..HEX1 = 7F if BCD_TIMER_BLANK_EN is defined, else 40.
- pause and start asserted together in RUN → PAUSED; start alone in EXPIRED → no change.
